// File: rtl/tone_tracker_if.sv
// Audio sample handshake between the tone generator and the audio controller.
// The generator offers a sample every cycle; the controller says when it can take one.
interface tone_tracker_if #(
    parameter int AMP_W = 32
);
    logic             out_allowed;
    logic             write_out;
    logic [AMP_W-1:0] sample_l;
    logic [AMP_W-1:0] sample_r;

    modport master (
        input  out_allowed,
        output write_out,
        output sample_l,
        output sample_r
    );

    modport slave (
        output out_allowed,
        input  write_out,
        input  sample_l,
        input  sample_r
    );
endinterface

// File: rtl/tone_tracker.sv
// Square-wave tone generator with a tick-driven saturating level tracker.
// The level walks toward LO, MID or HI according to the select band.
module tone_tracker #(
    parameter int SEL_W     = 4,
    parameter int HALF_BASE = 3000,
    parameter int HALF_STEP = 32768,
    parameter int CNT_W     = 20,
    parameter int AMP_W     = 32,
    parameter int AMPLITUDE = 10000000,
    parameter int TICK_DIV  = 50000000,
    parameter int LEVELS    = 9,
    parameter int LO_MAX    = 5,
    parameter int ME_MAX    = 10,
    localparam int LW       = $clog2(LEVELS),
    localparam int TW       = $clog2(TICK_DIV)
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [SEL_W-1:0]     sel,
    tone_tracker_if.master       aud,
    output logic [AMP_W-1:0]     snap,
    output logic                 tick,
    output logic [LW-1:0]        level,
    output logic [LW-1:0]        level_gray,
    output logic [1:0]           band
);

    typedef enum logic [1:0] {
        B_OFF = 2'd0,
        B_HI  = 2'd1,
        B_ME  = 2'd2,
        B_LO  = 2'd3
    } band_e;

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(HALF_STEP);
    localparam logic [CNT_W-1:0] BASE_C = CNT_W'(HALF_BASE);
    localparam logic [AMP_W-1:0] AMP_P  = AMP_W'(AMPLITUDE);
    localparam logic [AMP_W-1:0] AMP_N  = AMP_W'(-AMPLITUDE);
    localparam logic [TW-1:0]    TLAST  = TW'(TICK_DIV - 1);
    localparam logic [LW-1:0]    MID    = LW'((LEVELS - 1) / 2);
    localparam logic [LW-1:0]    TOP    = LW'(LEVELS - 1);
    localparam logic [SEL_W-1:0] LO_C   = SEL_W'(LO_MAX);
    localparam logic [SEL_W-1:0] ME_C   = SEL_W'(ME_MAX);

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] phase_cnt;
    logic             phase;
    logic [AMP_W-1:0] sample_val;
    logic [AMP_W-1:0] sample_q;
    logic [TW-1:0]    tick_cnt;
    logic [LW-1:0]    lvl_nxt;
    band_e            band_c;

    assign half = CNT_W'(sel) * STEP_C + BASE_C;

    // >= rather than == so a mid-period sel decrease toggles on the next cycle
    always_ff @(posedge CLOCK_50) begin
        if (reset || sel == '0) begin
            phase_cnt <= '0;
            phase     <= 1'b0;
        end else if (phase_cnt >= half - CNT_W'(1)) begin
            phase_cnt <= '0;
            phase     <= ~phase;
        end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        sample_val = '0;
        if (sel != '0)
            sample_val = phase ? AMP_P : AMP_N;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            sample_q <= '0;
        else
            sample_q <= sample_val;
    end

    assign aud.sample_l  = sample_q;
    assign aud.sample_r  = sample_q;
    assign aud.write_out = aud.out_allowed & ~reset;

    always_ff @(posedge CLOCK_50) begin
        if (reset || tick_cnt == TLAST)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    assign tick = (tick_cnt == TLAST) && !reset;

    always_comb begin
        band_c = B_OFF;
        unique case (1'b1)
            (sel == '0):                band_c = B_OFF;
            (sel != '0 && sel <= LO_C): band_c = B_LO;
            (sel > LO_C && sel <= ME_C): band_c = B_ME;
            (sel > LO_C && sel > ME_C): band_c = B_HI;
        endcase
    end

    assign band = band_c;

    always_comb begin
        lvl_nxt = level;
        unique case (band_c)
            B_LO: if (level != '0) lvl_nxt = level - LW'(1);
            B_HI: if (level != TOP) lvl_nxt = level + LW'(1);
            B_ME: begin
                if (level > MID)
                    lvl_nxt = level - LW'(1);
                else if (level < MID)
                    lvl_nxt = level + LW'(1);
            end
            B_OFF: lvl_nxt = level;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            level <= MID;
            snap  <= '0;
        end else if (tick) begin
            level <= lvl_nxt;
            snap  <= sample_q;
        end
    end

    assign level_gray = level ^ (level >> 1);

endmodule

// File: tb/tb_tone_tracker.sv
// Directed bench for tone_tracker with a small half period and tick divider.
// Each task resets the block and checks its scenario cycle by cycle.
module tb_tone_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sel = '0;
    logic [31:0] snap;
    logic       tick;
    logic [3:0] level;
    logic [3:0] level_gray;
    logic [1:0] band;
    int         total = 0;
    int         bad = 0;

    tone_tracker_if #(.AMP_W(32)) aud ();

    tone_tracker #(
        .SEL_W(4), .HALF_BASE(3), .HALF_STEP(2), .CNT_W(8),
        .AMP_W(32), .AMPLITUDE(100), .TICK_DIV(8), .LEVELS(9),
        .LO_MAX(5), .ME_MAX(10)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .sel(sel),
        .aud(aud),
        .snap(snap),
        .tick(tick),
        .level(level),
        .level_gray(level_gray),
        .band(band)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        aud.out_allowed = 1'b0;
        reset = 1'b1;
        sel = '0;
        step();
        step();
        aud.out_allowed = 1'b1;
        #1;
        total++;
        if (aud.write_out !== 1'b0) begin
            bad++;
            $display("FAIL rst_write: got %0b want 0", aud.write_out);
        end
        total++;
        if (aud.sample_l !== 32'd0 || aud.sample_r !== 32'd0) begin
            bad++;
            $display("FAIL rst_sample: got %0d/%0d want 0", aud.sample_l, aud.sample_r);
        end
        total++;
        if (snap !== 32'd0) begin
            bad++;
            $display("FAIL rst_snap: got %0d want 0", snap);
        end
        total++;
        if (level !== 4'd4 || level_gray !== 4'd6) begin
            bad++;
            $display("FAIL rst_level: got %0d/%0d want 4/6", level, level_gray);
        end
        total++;
        if (tick !== 1'b0) begin
            bad++;
            $display("FAIL rst_tick: got %0b want 0", tick);
        end
    endtask

    task automatic test_tone();
        int e;
        do_reset();
        sel = 4'd1;
        for (int k = 1; k <= 20; k++) begin
            step();
            e = (((k - 1) / 5) % 2 == 0) ? -100 : 100;
            total++;
            if (aud.sample_l !== 32'(e) || aud.sample_r !== 32'(e)) begin
                bad++;
                $display("FAIL tone_sample k=%0d: got %0d/%0d want %0d", k,
                         $signed(aud.sample_l), $signed(aud.sample_r), e);
            end
            total++;
            if (tick !== (k % 8 == 7)) begin
                bad++;
                $display("FAIL tone_tick k=%0d: got %0b", k, tick);
            end
            aud.out_allowed = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (aud.write_out !== aud.out_allowed) begin
                bad++;
                $display("FAIL tone_write k=%0d: got %0b want %0b", k,
                         aud.write_out, aud.out_allowed);
            end
        end
        total++;
        if (level !== 4'd2 || $signed(snap) !== -100) begin
            bad++;
            $display("FAIL tone_track: got lvl %0d snap %0d want 2 -100",
                     level, $signed(snap));
        end
    endtask

    task automatic test_off();
        int nt = 0;
        do_reset();
        sel = 4'd0;
        #1;
        total++;
        if (band !== 2'd0) begin
            bad++;
            $display("FAIL off_band: got %0d want 0", band);
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            if (tick)
                nt++;
            total++;
            if (aud.sample_l !== 32'd0 || aud.sample_r !== 32'd0) begin
                bad++;
                $display("FAIL off_sample k=%0d: got %0d/%0d want 0", k,
                         aud.sample_l, aud.sample_r);
            end
        end
        total++;
        if (nt != 2 || level !== 4'd4) begin
            bad++;
            $display("FAIL off_hold: got ticks %0d lvl %0d want 2 4", nt, level);
        end
    endtask

    task automatic test_lo();
        int el [6] = '{3, 2, 1, 0, 0, 0};
        int eg [6] = '{2, 3, 1, 0, 0, 0};
        do_reset();
        sel = 4'd2;
        #1;
        total++;
        if (band !== 2'd3) begin
            bad++;
            $display("FAIL lo_band: got %0d want 3", band);
        end
        for (int k = 1; k <= 48; k++) begin
            step();
            total++;
            if (tick !== (k % 8 == 7)) begin
                bad++;
                $display("FAIL lo_tick k=%0d: got %0b", k, tick);
            end
            if (k % 8 == 0) begin
                total++;
                if (level !== 4'(el[k/8-1]) || level_gray !== 4'(eg[k/8-1])) begin
                    bad++;
                    $display("FAIL lo_level k=%0d: got %0d/%0d want %0d/%0d", k,
                             level, level_gray, el[k/8-1], eg[k/8-1]);
                end
            end
        end
    endtask

    task automatic test_hi_me();
        int eh [5] = '{5, 6, 7, 8, 8};
        int em [5] = '{7, 6, 5, 4, 4};
        do_reset();
        sel = 4'd15;
        #1;
        total++;
        if (band !== 2'd1) begin
            bad++;
            $display("FAIL hi_band: got %0d want 1", band);
        end
        for (int k = 1; k <= 80; k++) begin
            step();
            if (k % 8 == 0) begin
                total++;
                if (k <= 40 && level !== 4'(eh[k/8-1])) begin
                    bad++;
                    $display("FAIL hi_level k=%0d: got %0d want %0d", k,
                             level, eh[k/8-1]);
                end else if (k > 40 && level !== 4'(em[k/8-6])) begin
                    bad++;
                    $display("FAIL me_level k=%0d: got %0d want %0d", k,
                             level, em[k/8-6]);
                end
            end
            if (k == 40) begin
                sel = 4'd7;
                #1;
                total++;
                if (band !== 2'd2) begin
                    bad++;
                    $display("FAIL me_band: got %0d want 2", band);
                end
            end
        end
    endtask

    task automatic test_sel_drop();
        int e;
        do_reset();
        sel = 4'd15;
        for (int k = 1; k <= 46; k++) begin
            step();
            if (k <= 31)
                e = -100;
            else
                e = (((k - 32) / 5) % 2 == 0) ? 100 : -100;
            total++;
            if (aud.sample_l !== 32'(e)) begin
                bad++;
                $display("FAIL drop_sample k=%0d: got %0d want %0d", k,
                         $signed(aud.sample_l), e);
            end
            if (k == 30)
                sel = 4'd1;
            if (k == 31) begin
                total++;
                if (dut.phase_cnt !== 8'd0) begin
                    bad++;
                    $display("FAIL drop_cnt: got %0d want 0", dut.phase_cnt);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        sel = 4'd2;
        for (int k = 1; k <= 19; k++)
            step();
        total++;
        if (level !== 4'd2 || $signed(snap) !== -100) begin
            bad++;
            $display("FAIL pre_reset: got lvl %0d snap %0d want 2 -100",
                     level, $signed(snap));
        end
        aud.out_allowed = 1'b1;
        reset = 1'b1;
        step();
        total++;
        if (level !== 4'd4 || aud.sample_l !== 32'd0 || snap !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset: got lvl %0d smp %0d snap %0d want 4 0 0",
                     level, aud.sample_l, snap);
        end
        total++;
        if (aud.write_out !== 1'b0 || tick !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_strobes: got wr %0b tick %0b want 0 0",
                     aud.write_out, tick);
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            total++;
            if (tick !== (k == 7)) begin
                bad++;
                $display("FAIL rel_tick k=%0d: got %0b want %0b", k, tick, k == 7);
            end
            if (k == 7 || k == 8) begin
                total++;
                if (aud.sample_l !== ((k == 7) ? 32'hFFFF_FF9C : 32'd100)) begin
                    bad++;
                    $display("FAIL rel_sample k=%0d: got %0d", k, $signed(aud.sample_l));
                end
            end
        end
        total++;
        if (level !== 4'd3) begin
            bad++;
            $display("FAIL rel_level: got %0d want 3", level);
        end
    endtask

    initial begin
        test_reset();
        test_tone();
        test_off();
        test_lo();
        test_hi_me();
        test_sel_drop();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
